// File: rtl/ddr3_rw_scheduler_pkg.sv
// Shared types and constants for the DDR3 read/write scheduler.
// State encoding, direction tags and output-FIFO geometry.
package ddr3_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_e;

  localparam int unsigned FIFO_SIZE  = 256;
  localparam int unsigned FIFO_CNT_W = 8;

endpackage

// File: rtl/ddr3_rw_scheduler_if.sv
// Scheduler <-> burst engine / FIFO status bundle.
// DDR3_RW_SCHEDULER_STATS_EN adds the statistics outputs.
interface ddr3_rw_scheduler_if
  import ddr3_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 26
) ();

  logic                  calib_done;
  logic [FIFO_CNT_W-1:0] ib_count;
  logic [FIFO_CNT_W-1:0] ob_count;
  logic                  engine_idle;
  logic                  wr_burst_done;
  logic                  rd_burst_done;
  logic                  writes_en;
  logic                  reads_en;
  logic [DEPTH_LOG2:0]   occupancy;
  logic                  ddr_full;
  logic                  ddr_empty;
`ifdef DDR3_RW_SCHEDULER_STATS_EN
  logic [31:0]           wr_bursts;
  logic [31:0]           rd_bursts;
  logic [15:0]           dir_switches;
  logic                  err_sticky;
`endif

  // Scheduler side
  modport master (
    input  calib_done, ib_count, ob_count, engine_idle, wr_burst_done, rd_burst_done,
    output writes_en, reads_en, occupancy, ddr_full, ddr_empty
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    , output wr_bursts, rd_bursts, dir_switches, err_sticky
`endif
  );

  // Engine / environment side
  modport slave (
    output calib_done, ib_count, ob_count, engine_idle, wr_burst_done, rd_burst_done,
    input  writes_en, reads_en, occupancy, ddr_full, ddr_empty
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    , input wr_bursts, rd_bursts, dir_switches, err_sticky
`endif
  );

endinterface

// File: rtl/ddr3_rw_scheduler_occupancy.sv
// Saturating up/down count of DDR bursts written but not yet read.
// DDR3_RW_SCHEDULER_STATS_EN adds a sticky overflow/underflow flag.
module ddr3_occupancy_counter #(
  parameter int unsigned DEPTH_LOG2 = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                full_c,
  output logic                empty_c
`ifdef DDR3_RW_SCHEDULER_STATS_EN
  , output logic              err_sticky_o
`endif
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_VAL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [CW-1:0] count_q;
  logic          up_c;
  logic          dn_c;

  // Simultaneous inc and dec cancel out
  assign up_c    = inc_i & ~dec_i;
  assign dn_c    = dec_i & ~inc_i;
  assign full_c  = (count_q == FULL_VAL);
  assign empty_c = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (up_c && !full_c) begin
      count_q <= count_q + CW'(1);
    end else if (dn_c && !empty_c) begin
      count_q <= count_q - CW'(1);
    end
  end

`ifdef DDR3_RW_SCHEDULER_STATS_EN
  logic err_sticky_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
    end else if ((up_c && full_c) || (dn_c && empty_c)) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky_o = err_sticky_q;
`endif

endmodule

// File: rtl/ddr3_rw_scheduler.sv
// Arbitrates the DDR3 burst engine between write and read directions,
// with a fairness quantum and drain gap. DDR3_RW_SCHEDULER_STATS_EN adds counters.
module ddr3_rw_scheduler
  import ddr3_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 26,
  parameter int unsigned QUANTUM     = 32,
  parameter int unsigned IB_THRESH   = 1,
  parameter int unsigned OB_HEADROOM = 3
) (
  input logic                  clk,
  input logic                  reset,
  ddr3_rw_scheduler_if.master  bus
);

  localparam int unsigned QW     = $clog2(QUANTUM + 1);
  localparam int unsigned FREE_W = FIFO_CNT_W + 1;

  state_e              state_q;
  dir_e                last_dir_q;
  logic [QW-1:0]       qcnt_q;
  logic                writes_en_q;
  logic                reads_en_q;
  logic                wr_ok_q;
  logic                rd_ok_q;

  logic [DEPTH_LOG2:0] occ;
  logic                full_c;
  logic                empty_c;
  logic [FREE_W-1:0]   ob_free_c;
  logic                wr_ok_c;
  logic                rd_ok_c;
  logic [QW-1:0]       qcnt_wr_d;
  logic [QW-1:0]       qcnt_rd_d;
  logic                wq_hit_c;
  logic                rq_hit_c;
  logic                grant_c;
  logic                pick_wr_c;

  ddr3_occupancy_counter #(.DEPTH_LOG2(DEPTH_LOG2)) u_occ (
    .clk          (clk),
    .reset        (reset),
    .inc_i        (bus.wr_burst_done),
    .dec_i        (bus.rd_burst_done),
    .count_o      (occ),
    .full_c       (full_c),
    .empty_c      (empty_c)
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    , .err_sticky_o (bus.err_sticky)
`endif
  );

  // Direction eligibility, registered before use by the FSM
  assign ob_free_c = FREE_W'(FIFO_SIZE) - {1'b0, bus.ob_count};
  assign wr_ok_c   = bus.calib_done && (bus.ib_count >= FIFO_CNT_W'(IB_THRESH)) && !full_c;
  assign rd_ok_c   = bus.calib_done && (ob_free_c >= FREE_W'(OB_HEADROOM)) && !empty_c;

  // Quantum counts the burst accepted this cycle, so the enable drops right after it
  assign qcnt_wr_d = qcnt_q + QW'(bus.wr_burst_done);
  assign qcnt_rd_d = qcnt_q + QW'(bus.rd_burst_done);
  assign wq_hit_c  = (qcnt_wr_d == QW'(QUANTUM));
  assign rq_hit_c  = (qcnt_rd_d == QW'(QUANTUM));

  assign grant_c   = (state_q == S_IDLE) && bus.calib_done && (wr_ok_q || rd_ok_q);
  assign pick_wr_c = wr_ok_q && (!rd_ok_q || (last_dir_q == DIR_READ));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_dir_q  <= DIR_READ;
      qcnt_q      <= '0;
      writes_en_q <= 1'b0;
      reads_en_q  <= 1'b0;
      wr_ok_q     <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      wr_ok_q <= wr_ok_c;
      rd_ok_q <= rd_ok_c;
      case (state_q)
        S_IDLE: begin
          if (grant_c) begin
            qcnt_q <= '0;
            if (pick_wr_c) begin
              state_q     <= S_WRITE;
              writes_en_q <= 1'b1;
            end else begin
              state_q    <= S_READ;
              reads_en_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!wr_ok_q || !bus.calib_done || (wq_hit_c && rd_ok_q)) begin
            state_q     <= S_DRAIN;
            writes_en_q <= 1'b0;
            last_dir_q  <= DIR_WRITE;
          end else if (wq_hit_c) begin
            qcnt_q <= '0;
          end else begin
            qcnt_q <= qcnt_wr_d;
          end
        end
        S_READ: begin
          if (!rd_ok_q || !bus.calib_done || (rq_hit_c && wr_ok_q)) begin
            state_q    <= S_DRAIN;
            reads_en_q <= 1'b0;
            last_dir_q <= DIR_READ;
          end else if (rq_hit_c) begin
            qcnt_q <= '0;
          end else begin
            qcnt_q <= qcnt_rd_d;
          end
        end
        S_DRAIN: begin
          if (bus.engine_idle) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.writes_en = writes_en_q;
  assign bus.reads_en  = reads_en_q;
  assign bus.occupancy = occ;
  assign bus.ddr_full  = full_c;
  assign bus.ddr_empty = empty_c;

`ifdef DDR3_RW_SCHEDULER_STATS_EN
  logic [31:0] wr_bursts_q;
  logic [31:0] rd_bursts_q;
  logic [15:0] dir_switches_q;
  logic        dir_switch_c;

  // A switch is a grant in the direction opposite the last one served
  assign dir_switch_c = grant_c && (pick_wr_c ? (last_dir_q == DIR_READ)
                                              : (last_dir_q == DIR_WRITE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bursts_q    <= '0;
      rd_bursts_q    <= '0;
      dir_switches_q <= '0;
    end else begin
      if (bus.wr_burst_done) wr_bursts_q    <= wr_bursts_q + 32'(1);
      if (bus.rd_burst_done) rd_bursts_q    <= rd_bursts_q + 32'(1);
      if (dir_switch_c)      dir_switches_q <= dir_switches_q + 16'(1);
    end
  end

  assign bus.wr_bursts    = wr_bursts_q;
  assign bus.rd_bursts    = rd_bursts_q;
  assign bus.dir_switches = dir_switches_q;
`endif

endmodule

// File: tb/tb_ddr3_rw_scheduler.sv
// Directed bench for ddr3_rw_scheduler (DEPTH_LOG2=3, QUANTUM=4).
// Extra checks compile in when DDR3_RW_SCHEDULER_STATS_EN is defined.
module tb_ddr3_rw_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ddr3_rw_scheduler_if #(.DEPTH_LOG2(3)) bus ();

  ddr3_rw_scheduler #(
    .DEPTH_LOG2  (3),
    .QUANTUM     (4),
    .IB_THRESH   (1),
    .OB_HEADROOM (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    bus.wr_burst_done = w;
    bus.rd_burst_done = r;
    step();
    bus.wr_burst_done = 1'b0;
    bus.rd_burst_done = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.calib_done    = 1'b0;
    bus.ib_count      = 8'd0;
    bus.ob_count      = 8'd0;
    bus.engine_idle   = 1'b0;
    bus.wr_burst_done = 1'b0;
    bus.rd_burst_done = 1'b0;
    repeat (3) step();
    check("rst_wen",   32'(bus.writes_en), 32'd0);
    check("rst_ren",   32'(bus.reads_en),  32'd0);
    check("rst_occ",   32'(bus.occupancy), 32'd0);
    check("rst_empty", 32'(bus.ddr_empty), 32'd1);
    check("rst_full",  32'(bus.ddr_full),  32'd0);
    reset = 1'b0;

    // Calibrated but no input data and empty DDR: nothing granted
    bus.calib_done = 1'b1;
    repeat (5) step();
    check("idle_wen",   32'(bus.writes_en), 32'd0);
    check("idle_ren",   32'(bus.reads_en),  32'd0);
    check("idle_empty", 32'(bus.ddr_empty), 32'd1);

    // Input data arrives: write granted two edges later
    bus.ib_count = 8'd10;
    repeat (2) step();
    check("wr_grant", 32'(bus.writes_en), 32'd1);
    repeat (4) pulse(1'b1, 1'b0);
    check("wr_quantum_end", 32'(bus.writes_en), 32'd0);
    pulse(1'b1, 1'b0);
    check("occ5",       32'(bus.occupancy), 32'd5);
    check("drain_ren",  32'(bus.reads_en),  32'd0);
    bus.engine_idle = 1'b1;
    step();
    check("gap_idle", 32'({bus.writes_en, bus.reads_en}), 32'd0);
    step();
    check("rd_grant",     32'(bus.reads_en),  32'd1);
    check("rd_grant_wen", 32'(bus.writes_en), 32'd0);

    // Read quantum of 4, then back to writes
    bus.engine_idle = 1'b0;
    repeat (4) pulse(1'b0, 1'b1);
    check("rd_quantum_end", 32'(bus.reads_en),  32'd0);
    check("occ1",           32'(bus.occupancy), 32'd1);
    bus.engine_idle = 1'b1;
    repeat (2) step();
    check("wr_regrant", 32'(bus.writes_en), 32'd1);

    // Output FIFO nearly full: reads ineligible, write quantum just restarts
    bus.ob_count = 8'd255;
    repeat (6) pulse(1'b1, 1'b0);
    check("occ7",      32'(bus.occupancy), 32'd7);
    check("wr_stays",  32'(bus.writes_en), 32'd1);
    pulse(1'b1, 1'b1);
    check("occ7_both", 32'(bus.occupancy), 32'd7);
    pulse(1'b1, 1'b0);
    check("full_flag",  32'(bus.ddr_full),  32'd1);
    check("full_empty", 32'(bus.ddr_empty), 32'd0);
    repeat (2) step();
    check("full_wen_drop", 32'(bus.writes_en), 32'd0);
    pulse(1'b1, 1'b0);
    check("occ_sat_full", 32'(bus.occupancy), 32'd8);
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    check("err_overflow", 32'(bus.err_sticky), 32'd1);
    check("wr_bursts",    bus.wr_bursts,       32'd14);
`endif

    // Reads resume once the output FIFO drains; calib loss drops them
    bus.ob_count = 8'd0;
    repeat (2) step();
    check("rd_after_full", 32'(bus.reads_en), 32'd1);
    pulse(1'b0, 1'b1);
    check("occ7_rd", 32'(bus.occupancy), 32'd7);
    bus.calib_done = 1'b0;
    step();
    check("calib_drop_ren", 32'(bus.reads_en), 32'd0);
    repeat (2) step();
    check("calib_low_grant", 32'({bus.writes_en, bus.reads_en}), 32'd0);

    // Asynchronous reset in the middle of a write grant
    bus.calib_done = 1'b1;
    repeat (2) step();
    check("wr_before_rst", 32'(bus.writes_en), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_wen",   32'(bus.writes_en), 32'd0);
    check("arst_ren",   32'(bus.reads_en),  32'd0);
    check("arst_occ",   32'(bus.occupancy), 32'd0);
    check("arst_empty", 32'(bus.ddr_empty), 32'd1);
    check("arst_full",  32'(bus.ddr_full),  32'd0);
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    check("arst_err", 32'(bus.err_sticky), 32'd0);
`endif
    #1;
    reset = 1'b0;

    // Read pulse at empty saturates at zero
    pulse(1'b0, 1'b1);
    check("occ_sat_empty", 32'(bus.occupancy), 32'd0);
    check("empty_after",   32'(bus.ddr_empty), 32'd1);
`ifdef DDR3_RW_SCHEDULER_STATS_EN
    check("err_underflow", 32'(bus.err_sticky), 32'd1);
`endif
    step();
    check("wr_after_rst", 32'(bus.writes_en), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
